// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state encoding, widths and helpers for mult_div_unit
package mult_div_pkg;
   localparam int WIDTH = 32;
   localparam int ITER_COUNT = 32;
   localparam int CNT_W = $clog2(ITER_COUNT);
   localparam int RES_W = 2 * WIDTH;
   typedef enum logic [1:0] {IDLE, DIV_CALC, MULT_CALC, FIX} state_t;
   function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: start/busy/done operand and result bundle between control unit and mult_div_unit
interface mult_div_unit_if;
   import mult_div_pkg::*;
   logic             start_div;
   logic             start_mult;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_zero;
   modport master (output start_div, start_mult, a, b, input hi, lo, busy, done, div_zero);
   modport slave  (input start_div, start_mult, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32-bit divider, multiplier built only with MULT_DIV_UNIT_MULT_EN
module mult_div_unit
   import mult_div_pkg::*;
(
   input logic            clk,
   input logic            reset,
   mult_div_unit_if.slave bus
);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, mag_q, mag_d, hi_q, hi_d, lo_q, lo_d;
   logic             neg_q, neg_d, sa_q, sa_d, done_q, done_d, zero_q, zero_d;
   logic [WIDTH:0]   shl, dif;
`ifdef MULT_DIV_UNIT_MULT_EN
   logic             mul_q, mul_d;
   logic [WIDTH:0]   sum;
`endif
   // rem/quo double as the upper/lower product halves so both operations share one shift register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         mag_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         sa_q    <= 1'b0;
         done_q  <= 1'b0;
         zero_q  <= 1'b0;
`ifdef MULT_DIV_UNIT_MULT_EN
         mul_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         mag_q   <= mag_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         sa_q    <= sa_d;
         done_q  <= done_d;
         zero_q  <= zero_d;
`ifdef MULT_DIV_UNIT_MULT_EN
         mul_q   <= mul_d;
`endif
      end
   end
   // next state: operand capture in IDLE, one restoring/shift-add step per CALC cycle, sign fix-up in FIX
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      mag_d   = mag_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      sa_d    = sa_q;
      done_d  = 1'b0;
      zero_d  = zero_q;
      shl     = {rem_q, quo_q[WIDTH-1]};
      dif     = shl - {1'b0, mag_q};
`ifdef MULT_DIV_UNIT_MULT_EN
      mul_d   = mul_q;
      sum     = {1'b0, rem_q} + {1'b0, mag_q};
`endif
      case (state_q)
         IDLE: begin
            rem_d   = '0;
            cnt_d   = '0;
            neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            sa_d    = bus.a[WIDTH-1];
            mag_d   = abs_w(bus.b);
            quo_d   = abs_w(bus.a);
            done_d  = bus.start_div && (bus.b == '0);
            zero_d  = bus.start_div ? (bus.b == '0) : zero_q;
            state_d = (bus.start_div && (bus.b != '0)) ? DIV_CALC : IDLE;
`ifdef MULT_DIV_UNIT_MULT_EN
            mul_d   = !bus.start_div;
            if (!bus.start_div && bus.start_mult) begin
               mag_d   = abs_w(bus.a);
               quo_d   = abs_w(bus.b);
               zero_d  = 1'b0;
               state_d = MULT_CALC;
            end
`endif
         end
         DIV_CALC: begin
            rem_d   = dif[WIDTH] ? shl[WIDTH-1:0] : dif[WIDTH-1:0];
            quo_d   = {quo_q[WIDTH-2:0], ~dif[WIDTH]};
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_W'(ITER_COUNT - 1)) ? FIX : DIV_CALC;
         end
`ifdef MULT_DIV_UNIT_MULT_EN
         MULT_CALC: begin
            {rem_d, quo_d} = {(quo_q[0] ? sum : {1'b0, rem_q}), quo_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_W'(ITER_COUNT - 1)) ? FIX : MULT_CALC;
         end
`endif
         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
            hi_d    = sa_q ? -rem_q : rem_q;
            lo_d    = neg_q ? -quo_q : quo_q;
`ifdef MULT_DIV_UNIT_MULT_EN
            if (mul_q) {hi_d, lo_d} = neg_q ? -{rem_q, quo_q} : {rem_q, quo_q};
`endif
         end
         default: state_d = IDLE;
      endcase
   end
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.busy     = state_q != IDLE;
   assign bus.done     = done_q;
   assign bus.div_zero = zero_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed bench comparing mult_div_unit to a cycle-level arithmetic model
module tb_mult_div_unit;
   import mult_div_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   mult_div_unit_if bus();
   mult_div_unit dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   int n_chk = 0;
   int n_fail = 0;
   bit live = 1'b0;
   int m_left = 0;
   logic m_done = 1'b0, m_zero = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // model: an accepted op delivers its signed-arithmetic result ITER_COUNT+1 edges later
   always @(posedge clk) begin
      longint sa, sb, q;
      sa = longint'($signed(bus.a));
      sb = longint'($signed(bus.b));
      if (reset) begin
         m_left = 0;
         m_done = 1'b0;
         m_zero = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_hi   = p_hi;
               m_lo   = p_lo;
            end
         end else if (bus.start_div) begin
            m_zero = (bus.b == 32'd0);
            if (m_zero) m_done = 1'b1;
            else begin
               m_left = ITER_COUNT + 1;
               q      = sa / sb;
               p_lo   = 32'(q);
               p_hi   = 32'(sa % sb);
            end
         end
`ifdef MULT_DIV_UNIT_MULT_EN
         else if (bus.start_mult) begin
            m_zero       = 1'b0;
            m_left       = ITER_COUNT + 1;
            {p_hi, p_lo} = sa * sb;
         end
`endif
      end
   end
   // compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (live) begin
         chk("busy", bus.busy, m_left > 0);
         chk("done", bus.done, m_done);
         chk("div_zero", bus.div_zero, m_zero);
         chk("hi", bus.hi, m_hi);
         chk("lo", bus.lo, m_lo);
      end
   end
   task automatic run_op(input bit sd, input bit sm, input logic [31:0] a, input logic [31:0] b, output int bc);
      bus.start_div  = sd;
      bus.start_mult = sm;
      bus.a          = a;
      bus.b          = b;
      @(negedge clk);
      bus.start_div  = 1'b0;
      bus.start_mult = 1'b0;
      bc = 0;
      for (int i = 0; i < 40 && !bus.done; i++) begin
         if (bus.busy) bc++;
         @(negedge clk);
      end
      chk("done_seen", bus.done, 1);
   endtask
   initial begin
      int bc, dones;
      logic [31:0] rh, rl;
      {bus.start_div, bus.start_mult, bus.a, bus.b} = '0;
      repeat (2) @(negedge clk);
      live = 1'b1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_zero", bus.div_zero, 0);
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);
      reset = 1'b0;
      @(negedge clk);
      run_op(1, 0, 7, 2, bc);
      chk("d7_2_busy_cycles", bc, 33);
      chk("d7_2_lo", bus.lo, 3);
      chk("d7_2_hi", bus.hi, 1);
      chk("d7_2_zero", bus.div_zero, 0);
      run_op(1, 0, 32'hFFFF_FFF9, 2, bc);
      chk("dm7_2_lo", bus.lo, 32'hFFFF_FFFD);
      chk("dm7_2_hi", bus.hi, 32'hFFFF_FFFF);
      run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, bc);
      chk("dmin_m1_lo", bus.lo, 32'h8000_0000);
      chk("dmin_m1_hi", bus.hi, 0);
      chk("dmin_m1_zero", bus.div_zero, 0);
      run_op(1, 0, 32'hFFFF_FF9C, 7, bc);
      chk("dm100_7_lo", bus.lo, 32'hFFFF_FFF2);
      chk("dm100_7_hi", bus.hi, 32'hFFFF_FFFE);
      run_op(1, 0, 100, 32'hFFFF_FFF9, bc);
      chk("d100_m7_lo", bus.lo, 32'hFFFF_FFF2);
      chk("d100_m7_hi", bus.hi, 2);
      run_op(1, 0, 32'h7FFF_FFFF, 1, bc);
      chk("dmax_1_lo", bus.lo, 32'h7FFF_FFFF);
      run_op(1, 0, 3, 10, bc);
      chk("d3_10_lo", bus.lo, 0);
      chk("d3_10_hi", bus.hi, 3);
      run_op(1, 0, 7, 2, bc);
      run_op(1, 0, 5, 0, bc);
      chk("dz_busy_cycles", bc, 0);
      chk("dz_busy", bus.busy, 0);
      chk("dz_flag", bus.div_zero, 1);
      chk("dz_hi_kept", bus.hi, 1);
      chk("dz_lo_kept", bus.lo, 3);
      @(negedge clk);
      chk("dz_flag_held", bus.div_zero, 1);
      chk("dz_done_single", bus.done, 0);
      run_op(1, 0, 9, 4, bc);
      chk("dz_cleared", bus.div_zero, 0);
      chk("d9_4_lo", bus.lo, 2);
      chk("d9_4_hi", bus.hi, 1);
      bus.start_div = 1'b1;
      bus.a = 100;
      bus.b = 7;
      @(negedge clk);
      bus.start_div = 1'b0;
      repeat (4) @(negedge clk);
      bus.start_div = 1'b1;
      bus.a = 1;
      bus.b = 1;
      @(negedge clk);
      bus.start_div = 1'b0;
      dones = 0;
      rh = '0;
      rl = '0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) begin
            dones++;
            rh = bus.hi;
            rl = bus.lo;
         end
         @(negedge clk);
      end
      chk("busy_ignore_dones", dones, 1);
      chk("busy_ignore_lo", rl, 14);
      chk("busy_ignore_hi", rh, 2);
      bus.start_div = 1'b1;
      bus.a = 50;
      bus.b = 3;
      @(negedge clk);
      bus.start_div = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_hi", bus.hi, 0);
      chk("midrst_lo", bus.lo, 0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      chk("midrst_no_done", dones, 0);
`ifdef MULT_DIV_UNIT_MULT_EN
      run_op(0, 1, 32'hFFFF_FFFD, 4, bc);
      chk("m_m3_4_busy_cycles", bc, 33);
      chk("m_m3_4_hi", bus.hi, 32'hFFFF_FFFF);
      chk("m_m3_4_lo", bus.lo, 32'hFFFF_FFF4);
      run_op(0, 1, 32'h8000_0000, 32'h8000_0000, bc);
      chk("m_min_min_hi", bus.hi, 32'h4000_0000);
      chk("m_min_min_lo", bus.lo, 0);
      run_op(1, 1, 7, 2, bc);
      chk("both_lo", bus.lo, 3);
      chk("both_hi", bus.hi, 1);
      run_op(1, 0, 1, 0, bc);
      run_op(0, 1, 6, 7, bc);
      chk("m_clears_zero", bus.div_zero, 0);
      chk("m_6_7_lo", bus.lo, 42);
`else
      run_op(1, 0, 7, 2, bc);
      bus.start_mult = 1'b1;
      bus.a = 5;
      bus.b = 6;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nomult_busy", bus.busy, 0);
         chk("nomult_done", bus.done, 0);
         chk("nomult_hi", bus.hi, 1);
         chk("nomult_lo", bus.lo, 3);
      end
      bus.start_mult = 1'b0;
`endif
      repeat (3) @(negedge clk);
      live = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed 32-bit multiply/divide unit for the multi-cycle MIPS datapath. It is the execution block the control unit drives for DIV (and optionally MULT) instructions. It takes operands from the A/B registers and returns a 64-bit result as `hi`/`lo` through a start/busy/done handshake. It also flags division by zero so the control unit can branch to its zero-divide exception state.

## Interface
- `WIDTH`, 32, operand width; fixed at 32 for this datapath.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_div`  in  1  request signed division `a / b`; sampled only in IDLE.
- `start_mult`  in  1  request signed multiplication `a * b`; sampled only in IDLE; ignored unless the MULT feature is compiled in.
- `a`  in  32  dividend / multiplicand (two's complement), sampled on the accepting edge.
- `b`  in  32  divisor / multiplier (two's complement), sampled on the accepting edge.
- `hi`  out  32  remainder (div) or upper product word (mult).
- `lo`  out  32  quotient (div) or lower product word (mult).
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  divide-by-zero flag.

## Operation
- States: IDLE, DIV_CALC, MULT_CALC, FIX. A 5-bit iteration counter drives the CALC states.
- **IDLE, `start_div`=1, `b`≠0:**
  - Latch |a|, |b| and the sign of a and of b.
  - Clear the working remainder; counter=0; go to DIV_CALC.
- **IDLE, `start_div`=1, `b`=0:**
  - Stay in IDLE; set `div_zero`=1 and `done`=1 for the next cycle.
  - `hi`/`lo` keep their previous values.
- **IDLE, `start_mult`=1 (feature on):** latch magnitudes and signs; clear the 64-bit accumulator; go to MULT_CALC.
- **Both starts high:** division wins; the mult request is dropped.
- **DIV_CALC:** one restoring step per cycle.
  - Shift {rem, quotient} left by 1.
  - If rem ≥ |b|, subtract and set the quotient LSB.
  - After 32 steps (counter wraps 31→0), go to FIX.
- **MULT_CALC:** one shift-add step per cycle over the 32 multiplier bits; then go to FIX.
- **FIX:** apply signs, write `hi`/`lo`, pulse `done`, return to IDLE.
- **Div sign rules:**
  - Quotient truncates toward zero and is negated when sign(a)≠sign(b).
  - Remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0, with no flag.
- **Mult sign rule:** the 64-bit product is negated when sign(a)≠sign(b).
- **`div_zero` lifetime:**
  - Set as described for `b`=0.
  - Cleared on the next accepted start of either kind.
  - Otherwise held.
- **Starts while busy:** ignored, with no queuing.

## Timing
- **Reset values:**
  - All outputs are 0 (`hi`, `lo`, `busy`, `done`, `div_zero`).
  - State=IDLE, counter=0.
- **Normal operation:** let E0 be the accepting edge.
  - Iterations occur on edges E1..E32.
  - FIX is active in the cycle after E32.
  - E33 writes `hi`/`lo` and returns to IDLE.
  - `done`=1 in the single cycle following E33.
- **busy:** high for exactly 33 cycles (after E0 through the FIX cycle); `busy` and `done` are never high together.
- **Result validity:** `hi`/`lo` are valid from the `done` cycle onward and hold until the next completion.
- **Divide by zero:** `done` follows E0 by one cycle; `busy` never rises.
- **Back-to-back:** a start presented during the `done` cycle is accepted at that cycle's ending edge (IDLE).
- **Reset mid-operation:** the next cycle shows all outputs 0 and state IDLE; no `done` pulse is produced for the aborted operation.

## Configuration
- `MULT_DIV_UNIT_MULT_EN` defined:
  - MULT_CALC and the multiply datapath are present.
  - `start_mult` behaves as described above.
- Undefined:
  - No multiply logic is built.
  - `start_mult` is a don't-care; asserting it never changes state, `busy`, `done`, `hi` or `lo`.
  - The port remains for a stable interface.

## Structure
- Shared package `mult_div_pkg`: the state encoding (IDLE, DIV_CALC, MULT_CALC, FIX), `ITER_COUNT`=32, and the result-width constants.
- Single flat module: the sign fix-up is two conditional negations and does not warrant a sub-module.
- The control unit consumes `done` and `div_zero`; it must wait on `done` rather than count cycles.

## Test plan
- `a`=7, `b`=2, `start_div` pulse → `busy` high for 33 cycles; then `done`=1 with `lo`=3, `hi`=1, `div_zero`=0.
- `a`=0xFFFFFFF9 (−7), `b`=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1); `a`=0x80000000, `b`=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Prior result `lo`=3, `hi`=1; then `a`=5, `b`=0 → `done` and `div_zero` high one cycle after start; `busy` stays 0; `hi`/`lo` remain 1/3; the next valid start clears `div_zero`.
- Division in progress, `start_div` re-asserted at cycle 5 → ignored, single `done` at cycle 33; `reset` at cycle 10 of a second run → all outputs 0 next cycle, no `done`.
- With `MULT_DIV_UNIT_MULT_EN`: `a`=0xFFFFFFFD (−3), `b`=4 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF4 after 33 busy cycles; `start_div` and `start_mult` together → division result only.
- Without `MULT_DIV_UNIT_MULT_EN`: `start_mult`=1 with any operands → `busy`, `done`, `hi`, `lo` unchanged.
